// File: rtl/imem_prog_ctrl_pkg.sv
// ============================================================================
// Module      : imem_prog_ctrl_pkg
// Description : Shared state encoding and defaults for the imem loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_prog_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [7:0]  C_MAGIC_DEFAULT     = 8'hA5;
  localparam int unsigned C_MAX_WORDS_DEFAULT = 4096;

endpackage

`default_nettype wire

// File: rtl/imem_prog_ctrl_word_packer.sv
// ============================================================================
// Module      : imem_word_packer
// Description : Little-endian byte-to-word assembler with word-ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_byte_valid) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_shift[7:0]   <= i_byte;
        2'd1:    r_shift[15:8]  <= i_byte;
        2'd2:    r_shift[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is complete
  // in the same cycle its 4th byte arrives.
  assign o_word       = {i_byte, r_shift};
  assign o_word_ready = i_byte_valid && !i_clear && (r_lane == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_prog_ctrl.sv
// ============================================================================
// Module      : imem_prog_ctrl
// Description : Serial-image loader that programs instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_prog_ctrl
  import imem_prog_ctrl_pkg::*;
#(
  parameter logic [7:0]  MAGIC     = C_MAGIC_DEFAULT,
  parameter logic [13:0] BASE_ADDR = 14'h0000,
  parameter int unsigned MAX_WORDS = C_MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [13:0] write_addr,
  output logic [31:0] write_data,
  output logic        w_en,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] C_MAX_LEN = 16'(MAX_WORDS);

  logic [2:0]  r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [13:0] r_addr;
  logic [7:0]  r_csum;
  logic        r_final;

  logic        w_pack_clear;
  logic        w_pack_valid;
  logic        w_word_ready;
  logic [31:0] w_word;
  logic [15:0] w_len;
  logic        w_last_word;
  logic        w_csum_byte;

  assign w_len        = {rx_data, r_len_lo};
  assign w_pack_clear = (r_state != S_DATA);
  assign w_pack_valid = rx_valid && (r_state == S_DATA) && !r_final;
  assign w_last_word  = (r_word_cnt == r_len - 16'd1);
  // r_final marks the write cycle of the last word; a byte in that cycle is
  // already the checksum byte.
  assign w_csum_byte  = rx_valid && ((r_state == S_CSUM) || ((r_state == S_DATA) && r_final));

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_pack_clear),
    .i_byte_valid (w_pack_valid),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_addr     <= BASE_ADDR;
      r_csum     <= '0;
      r_final    <= 1'b0;
      write_addr <= BASE_ADDR;
      write_data <= '0;
      w_en       <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      w_en    <= 1'b0;
      r_final <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_valid && (rx_data == MAGIC)) begin
            r_state  <= S_LEN_LO;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            r_len_lo <= rx_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            r_len      <= w_len;
            r_word_cnt <= '0;
            r_addr     <= BASE_ADDR;
            r_csum     <= '0;
            if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else if (w_len > C_MAX_LEN) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_final) begin
            if (!rx_valid) r_state <= S_CSUM;
          end else if (w_pack_valid) begin
            r_csum <= r_csum ^ rx_data;
            if (w_word_ready) begin
              w_en       <= 1'b1;
              write_addr <= r_addr;
              write_data <= w_word;
              r_addr     <= r_addr + 14'd4;
              r_word_cnt <= r_word_cnt + 16'd1;
              r_final    <= w_last_word;
            end
          end
        end
        S_CSUM: ;
        default: r_state <= S_IDLE;
      endcase

      if (w_csum_byte) begin
        if (rx_data == r_csum) begin
          r_state  <= S_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end else begin
          r_state <= S_ERR;
          error   <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_prog_ctrl.sv
// ============================================================================
// Module      : tb_imem_prog_ctrl
// Description : Randomized self-checking bench for imem_prog_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_prog_ctrl;

  localparam logic [13:0] BASE = 14'h0000;
  localparam int          MAXW = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [13:0] write_addr;
  logic [31:0] write_data;
  logic        w_en;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [45:0] got_q[$];
  logic [45:0] exp_q[$];
  logic [7:0]  pay_q[$];

  imem_prog_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .write_addr (write_addr),
    .write_data (write_data),
    .w_en       (w_en),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en === 1'b1) got_q.push_back({write_addr, write_data});
  end

  // ---------------- stimulus and reference helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic make_payload(input int nwords);
    pay_q.delete();
    for (int i = 0; i < nwords * 4; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] x = 8'h00;
    foreach (pay_q[i]) x = x ^ pay_q[i];
    return x;
  endfunction

  // Expected writes: word i is bytes 4i..4i+3 little-endian at BASE+4i.
  task automatic model_writes(input int nwords);
    exp_q.delete();
    for (int i = 0; i < nwords; i++)
      exp_q.push_back({BASE + 14'(4 * i),
                       pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
  endtask

  task automatic send_image(input logic [15:0] len, input logic [7:0] csum, input int maxgap);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(len[7:0], $urandom_range(0, maxgap));
    send_byte(len[15:8], $urandom_range(0, maxgap));
    foreach (pay_q[i]) send_byte(pay_q[i], $urandom_range(0, maxgap));
    send_byte(csum, $urandom_range(0, maxgap));
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] non_magic();
    logic [7:0] b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({w_en, write_addr, write_data, done, error, cpu_hold} !== {1'b0, BASE, 32'h0, 3'b001}) begin
      bad++;
      $display("FAIL reset_values: got w_en=%b addr=%h data=%h done=%b err=%b hold=%b want 0/%h/0/0/0/1",
               w_en, write_addr, write_data, done, error, cpu_hold, BASE);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_word();
    got_q.delete();
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_writes(2);
    send_image(16'd2, payload_xor(), 1);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL two_word_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL two_word_write%0d: got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL two_word_flags: got done/err/hold=%b want=100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_bad_csum();
    got_q.delete();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_writes(1);
    send_image(16'd1, 8'hFF, 2);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL bad_csum_write: got n=%0d first=%h want n=1 first=%h",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 46'h0, exp_q[0]);
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      bad++; $display("FAIL bad_csum_flags: got done/err/hold=%b want=011", {done, error, cpu_hold});
    end
  endtask

  task automatic test_too_long();
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    @(negedge clk);
    total++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      bad++; $display("FAIL too_long_flags: got done/err/hold=%b want=011", {done, error, cpu_hold});
    end
    pay_q.delete();
    send_image(16'd0, 8'h00, 0);
    total++;
    if (got_q.size() != 0) begin
      bad++; $display("FAIL too_long_writes: got=%0d want=0", got_q.size());
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL zero_len_flags: got done/err/hold=%b want=100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    make_payload(3);
    model_writes(3);
    send_image(16'd3, payload_xor(), 0);
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL b2b_count: got=%0d want=3", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_write%0d: got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL b2b_flags: got done/err/hold=%b want=100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_magic_payload();
    got_q.delete();
    pay_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
    model_writes(1);
    send_image(16'd1, payload_xor(), 1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {BASE, 32'hA5A5A5A5}) begin
      bad++; $display("FAIL magic_payload_write: got n=%0d first=%h want %h",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 46'h0, {BASE, 32'hA5A5A5A5});
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL magic_payload_flags: got done/err/hold=%b want=100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    make_payload(2);
    model_writes(1);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(pay_q[i], 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({w_en, write_addr, write_data, done, error, cpu_hold} !== {1'b0, BASE, 32'h0, 3'b001}) begin
      bad++; $display("FAIL async_reset: got w_en=%b addr=%h data=%h done/err/hold=%b want 0/%h/0/001",
                      w_en, write_addr, write_data, {done, error, cpu_hold}, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL reset_mid_write: got n=%0d first=%h want n=1 first=%h",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 46'h0, exp_q[0]);
    end
    got_q.delete();
    for (int i = 0; i < 9; i++) send_byte(non_magic(), 0);
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != 0 || {done, error, cpu_hold} !== 3'b001) begin
      bad++; $display("FAIL stray_ignored: got writes=%0d done/err/hold=%b want 0/001",
                      got_q.size(), {done, error, cpu_hold});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int nw;
      bit corrupt;
      logic [7:0] cs;
      got_q.delete();
      nw = $urandom_range(1, 6);
      corrupt = ($urandom_range(0, 2) == 0);
      make_payload(nw);
      model_writes(nw);
      cs = payload_xor() ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'h00);
      for (int s = $urandom_range(0, 3); s > 0; s--) send_byte(non_magic(), $urandom_range(0, 2));
      send_image(16'(nw), cs, 3);
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count: got=%0d want=%0d", n, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_write%0d: got=%h want=%h", n, i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if ({done, error, cpu_hold} !== (corrupt ? 3'b011 : 3'b100)) begin
        bad++; $display("FAIL rand%0d_flags: got done/err/hold=%b want=%b", n,
                        {done, error, cpu_hold}, corrupt ? 3'b011 : 3'b100);
      end
    end
  endtask

  task automatic test_max_len();
    int nbad = 0;
    got_q.delete();
    make_payload(MAXW);
    model_writes(MAXW);
    send_image(16'(MAXW), payload_xor(), 0);
    total++;
    if (got_q.size() != MAXW) begin
      bad++; $display("FAIL max_len_count: got=%0d want=%0d", got_q.size(), MAXW);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (nbad < 5) $display("FAIL max_len_write%0d: got=%h want=%h", i, got_q[i], exp_q[i]);
        nbad++;
      end
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL max_len_flags: got done/err/hold=%b want=100", {done, error, cpu_hold});
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bad_csum();
    test_too_long();
    test_back_to_back();
    test_magic_payload();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
